// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline registers: exception source indices,
// cause encoding, default NOP payload and the default-width entry layout.
package cpu_pipe_pkg;

    localparam int EXC_ILLOP  = 0;
    localparam int EXC_XADR   = 1;
    localparam int CAUSE_NONE = 0;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [1:0]  cause;
    } entry_t;

    // Cause field must encode "none" plus one code per exception source.
    function automatic bit cause_w_ok(input int num_exc, input int cause_w);
        return (64'd1 << cause_w) >= 64'(num_exc + 1);
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder: cause = index of lowest set request + 1,
// or 0 when no request is set.
module exc_prio_enc #(
    parameter int NUM_EXC = 2,
    parameter int CAUSE_W = 2
) (
    input  logic [NUM_EXC-1:0] req,
    output logic               any,
    output logic [CAUSE_W-1:0] cause
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        any   = 1'b0;
        cause = {CAUSE_W{1'b0}};
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            any = any | req[i];
            if (req[i]) begin
                cause = CAUSE_W'(i + 1);
            end else begin
                cause = cause;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid_chk.sv
// Protocol checks for pipe_stage_skid: ready mirrors skid state, occupancy
// bookkeeping, and held entries stay stable under back-pressure.
module pipe_stage_skid_chk #(
    parameter int W = 67
) (
    input logic         clk,
    input logic         reset,
    input logic         flush,
    input logic         in_ready,
    input logic         skid_valid,
    input logic         out_valid,
    input logic         out_ready,
    input logic [1:0]   occupancy,
    input logic [W-1:0] main_word,
    input logic [W-1:0] skid_word
);

    a_ready_mirror: assert property (@(posedge clk) disable iff (reset)
        in_ready == !skid_valid);

    a_occupancy: assert property (@(posedge clk) disable iff (reset)
        occupancy == ({1'b0, out_valid} + {1'b0, skid_valid}));

    a_skid_needs_main: assert property (@(posedge clk) disable iff (reset)
        skid_valid |-> out_valid);

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(main_word)));

    // A full skid must never be overwritten, i.e. nothing is accepted while not ready.
    a_no_accept_when_full: assert property (@(posedge clk) disable iff (reset)
        (skid_valid && !out_ready && !flush) |=> (skid_valid && $stable(skid_word)));

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, 2-entry
// skid buffer (registered in_ready), exception folding and flush-to-NOP.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                PC_W      = 32,
    parameter int                NUM_EXC   = 2,
    parameter int                CAUSE_W   = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [NUM_EXC-1:0] in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_exc,
    output logic [CAUSE_W-1:0] out_cause,
    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]  instr;
        logic [PC_W-1:0]    pc;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
    } stage_entry_t;

    localparam stage_entry_t NOP_ENTRY = '{
        instr: NOP_INSTR,
        pc:    {PC_W{1'b0}},
        exc:   1'b0,
        cause: CAUSE_W'(CAUSE_NONE)
    };

    if (!cause_w_ok(NUM_EXC, CAUSE_W)) begin : g_cause_w_check
        $error("pipe_stage_skid: CAUSE_W too small to encode NUM_EXC causes");
    end

    stage_entry_t main_q, main_d;
    stage_entry_t skid_q, skid_d;
    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [1:0]   occupancy_q, occupancy_d;

    logic               exc_any_s;
    logic [CAUSE_W-1:0] exc_cause_s;
    stage_entry_t       new_entry_s;
    logic               accept_s;
    logic               load_main_s;

    exc_prio_enc #(
        .NUM_EXC (NUM_EXC),
        .CAUSE_W (CAUSE_W)
    ) u_exc_prio_enc (
        .req   (in_exc),
        .any   (exc_any_s),
        .cause (exc_cause_s)
    );

    // Encode the incoming entry; a faulting entry becomes a NOP that keeps its PC as EPC.
    always_comb begin
        new_entry_s.pc = in_pc;
        if (exc_any_s) begin
            new_entry_s.instr = NOP_INSTR;
            new_entry_s.exc   = 1'b1;
            new_entry_s.cause = exc_cause_s;
        end else begin
            new_entry_s.instr = in_instr;
            new_entry_s.exc   = 1'b0;
            new_entry_s.cause = CAUSE_W'(CAUSE_NONE);
        end
    end

    assign accept_s    = in_valid & in_ready_q;
    assign load_main_s = !out_valid_q | out_ready;

    // Next-state for main/skid registers; flush overrides drain, accept and capture.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_d       = NOP_ENTRY;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_main_s) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_d      = new_entry_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_d       = new_entry_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d  = !skid_valid_d;
        occupancy_d = {1'b0, out_valid_d} + {1'b0, skid_valid_d};
    end

    // State registers; reset drops every entry without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= NOP_ENTRY;
            skid_q       <= NOP_ENTRY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occupancy_q  <= 2'd0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_exc   = main_q.exc;
    assign out_cause = main_q.cause;
    assign occupancy = occupancy_q;

    pipe_stage_skid_chk #(
        .W ($bits(stage_entry_t))
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_ready   (in_ready_q),
        .skid_valid (skid_valid_q),
        .out_valid  (out_valid_q),
        .out_ready  (out_ready),
        .occupancy  (occupancy_q),
        .main_word  (main_q),
        .skid_word  (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted entries are modelled as a FIFO
// of at most two held entries; a negedge monitor compares the DUT against it.
module tb_pipe_stage_skid;
    import cpu_pipe_pkg::*;

    localparam int NUM_EXC = 2;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_exc;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [1:0]  in_exc, out_cause, occupancy;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [1:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    pipe_stage_skid dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_exc   (out_exc),
        .out_cause (out_cause),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Expected entry: exception entries become a NOP carrying the lowest faulting source.
    function automatic exp_t model_entry(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [1:0] exc);
        exp_t e;
        int   k = 0;
        while (k < NUM_EXC && !exc[k]) k++;
        e.pc = pc;
        if (k < NUM_EXC) begin
            e.instr = NOP_INSTR_DEFAULT;
            e.exc   = 1'b1;
            e.cause = 2'(k + 1);
        end else begin
            e.instr = ins;
            e.exc   = 1'b0;
            e.cause = 2'd0;
        end
        return e;
    endfunction

    // One clock of stimulus; the expected entry is queued once the accepting edge has passed.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [1:0] exc, input logic ordy, input logic fl);
        logic rdy_seen;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        in_exc    = exc;
        out_ready = ordy;
        flush     = fl;
        rdy_seen  = in_ready;
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        else if (v && rdy_seen) exp_q.push_back(model_entry(ins, pc, exc));
    endtask

    // Monitor: state against the model, head entry against the outputs, pop on drain.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                chk("out_exc", 64'(out_exc), 64'(exp_q[0].exc));
                chk("out_cause", 64'(out_cause), 64'(exp_q[0].cause));
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_instr"}, 64'(out_instr), 64'(NOP_INSTR_DEFAULT));
        chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
        chk({tag, "_out_exc"}, 64'(out_exc), 64'd0);
        chk({tag, "_out_cause"}, 64'(out_cause), 64'd0);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  xadr_only;
        logic [31:0] pc_r;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; in_exc = 2'b00;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Streaming, one per cycle, no bubbles.
        for (int i = 0; i < 3; i++) begin
            pc_r = 32'h0040_0000 + 32'(4 * i);
            step(1'b1, 32'h2000_0000 + 32'(i), pc_r, 2'b00, 1'b1, 1'b0);
            chk("stream_pc", 64'(out_pc), 64'(pc_r));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Back-pressure: main holds A, skid takes B, C waits upstream.
        step(1'b1, 32'hA000_0000, 32'h0040_0000, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'hA000_0004, 32'h0040_0004, 2'b00, 1'b0, 1'b0);
        chk("bp_full_occ", 64'(occupancy), 64'd2);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hA000_0008, 32'h0040_0008, 2'b00, 1'b0, 1'b0);
        chk("bp_hold_pc", 64'(out_pc), 64'h0040_0000);
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hA000_0008, 32'h0040_0008, 2'b00, 1'b1, 1'b0);
        chk("bp_release_pc", 64'(out_pc), 64'h0040_0004);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_occ", 64'(occupancy), 64'd1);
        step(1'b1, 32'hA000_0008, 32'h0040_0008, 2'b00, 1'b1, 1'b0);
        chk("bp_third_pc", 64'(out_pc), 64'h0040_0008);
        step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);

        // Exceptions: both set -> illop wins; xadr alone -> cause 2.
        step(1'b1, 32'h8C08_0000, 32'h0040_0010, 2'b11, 1'b1, 1'b0);
        chk("exc_both_instr", 64'(out_instr), 64'd0);
        chk("exc_both_exc", 64'(out_exc), 64'd1);
        chk("exc_both_cause", 64'(out_cause), 64'(EXC_ILLOP + 1));
        chk("exc_both_pc", 64'(out_pc), 64'h0040_0010);
        xadr_only = 2'b00;
        xadr_only[EXC_XADR] = 1'b1;
        step(1'b1, 32'h8C08_0000, 32'h0040_0014, xadr_only, 1'b1, 1'b0);
        chk("exc_xadr_cause", 64'(out_cause), 64'(EXC_XADR + 1));
        chk("exc_xadr_instr", 64'(out_instr), 64'd0);
        step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);

        // Flush at occupancy 1 while in_ready=1: input is discarded.
        step(1'b1, 32'hB000_0018, 32'h0040_0018, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0020, 32'h0040_0020, 2'b00, 1'b0, 1'b1);
        chk_idle("flush1");
        // Flush at occupancy 2 with an input presented.
        step(1'b1, 32'hB000_0030, 32'h0040_0030, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0034, 32'h0040_0034, 2'b01, 1'b0, 1'b0);
        chk("flush2_pre_occ", 64'(occupancy), 64'd2);
        step(1'b1, 32'hB000_0020, 32'h0040_0020, 2'b00, 1'b1, 1'b1);
        chk_idle("flush2");
        repeat (3) step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);

        // Reset mid-stream at occupancy 2, checked before any clock edge.
        step(1'b1, 32'hC000_0040, 32'h0040_0040, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0044, 32'h0040_0044, 2'b00, 1'b0, 1'b0);
        chk("rst_pre_occ", 64'(occupancy), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk_idle("rst_mid");
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Random valid/ready/flush/exception stress against the FIFO model.
        for (int n = 0; n < 10000; n++) begin
            step(1'($urandom_range(0, 9) < 7),
                 $urandom(),
                 $urandom() & 32'hFFFF_FFFC,
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 39) == 0));
        end
        repeat (3) step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);
        chk("final_occupancy", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
